// File: rtl/inbuf_fifo.sv
// inbuf_fifo: DEPTH-entry elastic input buffer with valid/stop handshake.
// Optional zero-latency bypass when empty, synchronous flush, level/afull.
// istop depends only on registered count (plus reset), so cstop never
// reaches istop combinationally.
module inbuf_fifo #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 1,
  parameter int AFULL  = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic signed [WIDTH-1:0]    idata,
  input  logic                       ivalid,
  output logic                       istop,
  output logic signed [WIDTH-1:0]    cdata,
  output logic                       cvalid,
  input  logic                       cstop,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       afull
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [LW-1:0] cnt_t;

  logic signed [WIDTH-1:0] mem_q [DEPTH];
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;

  logic empty, push, pop, byp, wr_en, rd_en;

  // Pointers wrap at DEPTH-1, so DEPTH need not be a power of two.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH-1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Core-side outputs and status; reset forces istop high and cvalid low.
  always_comb begin
    empty  = (count_q == '0);
    istop  = !rst_n || (count_q == cnt_t'(DEPTH));
    cvalid = 1'b0;
    cdata  = '0;
    if (!empty) begin
      cvalid = 1'b1;
      cdata  = mem_q[rd_ptr_q];
    end else if (BYPASS != 0) begin
      cvalid = ivalid;
      cdata  = idata;
    end
    if (!rst_n) cvalid = 1'b0;
    level = count_q;
    afull = (count_q >= cnt_t'(AFULL));
  end

  // Handshake decode and next-state; flush wins over push and pop.
  always_comb begin
    push     = ivalid && !istop;
    pop      = cvalid && !cstop;
    // An accepted word that the core takes in the same cycle skips mem.
    byp      = (BYPASS != 0) && empty && !cstop;
    wr_en    = push && !byp && !flush;
    rd_en    = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage array; contents are intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= idata;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule
